// File: rtl/aes_pkg.sv
// Shared widths, round count, FSM state encoding and the GF(2^8) xtime helper
// for the AES-128 key expansion block.
package aes_pkg;

  localparam int AES_KEY_W   = 128;
  localparam int AES_WRD_W   = 32;
  localparam int AES_NUM_RND = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; also advances rcon.
  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box on a 32-bit word, computed from the GF(2^8) inverse and
// the affine transform rather than a lookup table; purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_WRD_W-1:0] i_wrd_sbox,
  output logic [AES_WRD_W-1:0] o_wrd_sbox
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aes_xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0), built from x^2..x^128.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    o_wrd_sbox = '0;
    for (int i = 0; i < 4; i++) begin
      o_wrd_sbox[i*8 +: 8] = sbox_byte(i_wrd_sbox[i*8 +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: emits round keys 0..10 over a valid/ready port, one per
// cycle when the consumer is always ready. Define AES_KEY_STORE_EN to keep a readable copy.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [AES_KEY_W-1:0] i_key,
  output logic [AES_KEY_W-1:0] o_rk,
  output logic                 o_rk_vld,
  input  logic                 i_rk_rdy,
  output logic [3:0]           o_rk_idx,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic [3:0]           i_rd_idx,
  output logic [AES_KEY_W-1:0] o_rd_key,
  output logic [1:0]           o_dbg_state
);

  localparam logic [3:0] LAST_IDX = 4'(AES_NUM_RND);

  aes_state_e          state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           rcon_q, rcon_d;

  logic [AES_WRD_W-1:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic [AES_WRD_W-1:0] sub_wrd, temp;
  logic                 hs;

  assign {w0, w1, w2, w3} = key_q;

  aes_sbox u_sbox (
    .i_wrd_sbox ({w3[23:0], w3[31:24]}),
    .o_wrd_sbox (sub_wrd)
  );

  assign temp = sub_wrd ^ {rcon_q, 24'h0};
  assign w4   = w0 ^ temp;
  assign w5   = w1 ^ w4;
  assign w6   = w2 ^ w5;
  assign w7   = w3 ^ w6;

  // Valid/ready: o_rk_vld stays high and o_rk/o_rk_idx hold until a cycle where
  // i_rk_rdy is also high; only that edge transfers the key and advances.
  assign hs = o_rk_vld & i_rk_rdy;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          key_d   = i_key;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            key_d  = {w4, w5, w6, w7};
            idx_d  = idx_q + 4'd1;
            rcon_d = aes_xtime(rcon_q);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign o_rk        = key_q;
  assign o_rk_idx    = idx_q;
  assign o_rk_vld    = (state_q == ST_EMIT);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_dbg_state = state_q;

`ifdef AES_KEY_STORE_EN
  logic [AES_KEY_W-1:0] store_q [0:AES_NUM_RND];
  logic [AES_KEY_W-1:0] store_d [0:AES_NUM_RND];

  always_comb begin
    store_d = store_q;
    for (int i = 0; i <= AES_NUM_RND; i++) begin
      if (state_q == ST_IDLE && i_start) begin
        store_d[i] = '0;
      end else if (hs && idx_q == 4'(i)) begin
        store_d[i] = key_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i <= AES_NUM_RND; i++) store_q[i] <= '0;
    end else begin
      store_q <= store_d;
    end
  end

  // Indices beyond the last round match no entry and read as zero.
  always_comb begin
    o_rd_key = '0;
    for (int i = 0; i <= AES_NUM_RND; i++) begin
      if (i_rd_idx == 4'(i)) o_rd_key = store_q[i];
    end
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^i_rd_idx;
  assign o_rd_key      = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 schedule, random back-pressure,
// ignored restart, mid-run reset and the optional stored-key read port.
module tb_aes_key_expand;
  import aes_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_start = 1'b0;
  logic [127:0] i_key = '0;
  logic         i_rk_rdy = 1'b0;
  logic [3:0]   i_rd_idx = '0;
  logic [127:0] o_rk, o_rd_key;
  logic         o_rk_vld, o_busy, o_done;
  logic [3:0]   o_rk_idx;
  logic [1:0]   o_dbg_state;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_key       (i_key),
    .o_rk        (o_rk),
    .o_rk_vld    (o_rk_vld),
    .i_rk_rdy    (i_rk_rdy),
    .o_rk_idx    (o_rk_idx),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_rd_idx    (i_rd_idx),
    .o_rd_key    (o_rd_key),
    .o_dbg_state (o_dbg_state)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  vec_t         fips_tbl [11];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q [$];
  logic         chk_q [$];
  int           exp_idx;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rk"},    o_rk, '0);
    check({tag, "_vld"},   o_rk_vld, 0);
    check({tag, "_idx"},   o_rk_idx, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_rd"},    o_rd_key, '0);
    check({tag, "_state"}, o_dbg_state, ST_IDLE);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_start = 1'b0; i_rk_rdy = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic start_key(input logic [127:0] k);
    @(negedge clk);
    i_key = k; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Consumes exp_q while the DUT emits; runs from the negedge just after start.
  task automatic run_exp(input int rdy_mode, input int start_at, input int rst_at,
                         output int emit_cyc);
    bit fin = 0;
    emit_cyc = 0;
    exp_idx  = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
`ifndef AES_KEY_STORE_EN
      check("rd_key_zero", o_rd_key, '0);
`endif
      if (o_rk_vld) begin
        emit_cyc++;
        if (exp_q.size() == 0) begin
          check("extra_key_vld", o_rk_vld, 0);
          fin = 1;
        end else begin
          if (chk_q[0]) check($sformatf("rk%0d", exp_idx), o_rk, exp_q[0]);
          check($sformatf("rk_idx%0d", exp_idx), o_rk_idx, exp_idx);
          check("busy_emit", o_busy, 1);
          if (rst_at == exp_idx) begin
            i_rst = 1'b1; i_rk_rdy = 1'b0;
            @(negedge clk);
            i_rst = 1'b0;
            return;
          end
          i_start = (start_at == exp_idx);
          if (i_start) i_key = {4{32'hdeadbeef}};
          i_rk_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          if (i_rk_rdy) begin
            void'(exp_q.pop_front());
            void'(chk_q.pop_front());
            exp_idx++;
          end
        end
      end else begin
        check("done_pulse", o_done, exp_q.size() == 0);
        check("busy_in_done", o_busy, 1);
        i_rk_rdy = 1'b0;
        @(negedge clk);
        check("done_low", o_done, 0);
        check("busy_low", o_busy, 0);
        check("vld_low", o_rk_vld, 0);
        fin = 1;
      end
      @(negedge clk);
      i_start = 1'b0;
    end
    i_rk_rdy = 1'b0;
    check("run_finished", fin, 1);
  endtask

  task automatic load_fips();
    exp_q.delete(); chk_q.delete();
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(fips_tbl[i].key);
      chk_q.push_back(1'b1);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int emit_cyc;
    fips_tbl[0].key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_tbl[1].key  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_tbl[2].key  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_tbl[3].key  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_tbl[4].key  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_tbl[5].key  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_tbl[6].key  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_tbl[7].key  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_tbl[8].key  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_tbl[9].key  = 128'hac7766f319fadc2128d12941575c006e;
    fips_tbl[10].key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) fips_tbl[i].idx = 4'(i);

    do_reset();
    check_reset_outputs("reset");

    // FIPS-197 key, ready tied high: 11 emit cycles then a done pulse
    load_fips();
    start_key(fips_tbl[0].key);
    check("latency_vld", o_rk_vld, 1);
    run_exp(0, -1, -1, emit_cyc);
    check("emit_cycles", emit_cyc, 11);

    // stored keys, table-driven, plus out-of-range reads
    for (int i = 0; i < 11; i++) begin
      i_rd_idx = fips_tbl[i].idx;
      #1;
`ifdef AES_KEY_STORE_EN
      check($sformatf("store%0d", i), o_rd_key, fips_tbl[i].key);
`else
      check($sformatf("store_off%0d", i), o_rd_key, '0);
`endif
    end
    i_rd_idx = 4'd15; #1;
    check("store_rd15", o_rd_key, '0);
    i_rd_idx = 4'd11; #1;
    check("store_rd11", o_rd_key, '0);
    i_rd_idx = 4'd1;

    // random back-pressure with an ignored start at idx 4
    load_fips();
    start_key(fips_tbl[0].key);
    run_exp(1, 4, -1, emit_cyc);
    check("stall_cycles_min", emit_cyc >= 11, 1);

    // reset at idx 6, then a fresh expansion of a second key
    load_fips();
    start_key(fips_tbl[0].key);
    run_exp(1, -1, 6, emit_cyc);
    check_reset_outputs("midrst");

    exp_q.delete(); chk_q.delete();
    exp_q.push_back(128'h000102030405060708090a0b0c0d0e0f); chk_q.push_back(1'b1);
    for (int i = 1; i < 10; i++) begin
      exp_q.push_back('0); chk_q.push_back(1'b0);
    end
    exp_q.push_back(128'h13111d7fe3944a17f307a78b4d2b30c5); chk_q.push_back(1'b1);
    start_key(128'h000102030405060708090a0b0c0d0e0f);
    run_exp(0, -1, -1, emit_cyc);
    check("emit_cycles2", emit_cyc, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
